wb_trap_unit: RTL and testbench
===============================

Name: wb_trap_unit

Overview:
- Parametrised writeback stage with an integrated machine-mode trap sequencer.
- Selects and registers the register-file write data, and drives CSR writes for CSR instructions.
- Prioritises synchronous exceptions and interrupts. Sequences trap entry (mepc, mcause, mtval, mstatus) over the single CSR write port while stalling and flushing the pipe. Also executes MRET.
- Sits after the memory stage; its outputs feed the register file, the CSR file and the fetch PC mux.

Parameters:
XLEN, 64, datapath and CSR width
NUM_IRQ, 2, interrupt pending lines; bit i maps to cause IRQ_CAUSE[i] (package table: bit0 = 7 timer, bit1 = 11 external)

Ports:
CLK  in  1  clock
RESET  in  1  synchronous, active-high reset
WB_V  in  1  writeback instruction valid
WB_IR  in  32  instruction
WB_PC  in  XLEN  instruction PC
WB_NPC  in  XLEN  PC+4
WB_ALU_RESULT  in  XLEN  ALU result / branch target
WB_MEM_RESULT  in  XLEN  load data
WB_CSR_RDATA  in  XLEN  old CSR value, destined for rd
WB_CSR_WDATA  in  XLEN  new CSR value computed upstream
WB_DRID  in  5  destination register
WB_PC_MUX  in  1  branch/jump taken
WB_EXC  in  8  [0]IAM [1]IAF [2]II [3]ECALL [4]LAM [5]LAF [6]SAM [7]SAF
WB_TVAL  in  XLEN  faulting address or instruction
IRQ_PEND  in  NUM_IRQ  pending and enabled (mip&mie) interrupt lines
MSTATUS_IN  in  XLEN  current mstatus
MTVEC_IN  in  XLEN  trap vector (direct mode; bits[1:0] ignored)
MEPC_IN  in  XLEN  current mepc
PRIVILEGE  in  2  current privilege (0 = U, 3 = M)
RF_WE  out  1  register write strobe
RF_WADDR  out  5  register address
RF_WDATA  out  XLEN  register data
CSR_WE  out  1  CSR write strobe
CSR_WADDR  out  12  CSR address
CSR_WDATA  out  XLEN  CSR data
PC_REDIRECT  out  1  load REDIRECT_PC into fetch
REDIRECT_PC  out  XLEN  branch / trap / mret target
FLUSH  out  1  kill all younger stages
STALL  out  1  hold all upstream stages
TRAP_TAKEN  out  1  one-cycle pulse on trap commit

Behaviour:
- Reset:
  - All outputs are 0 and the FSM is IDLE.
  - Reset mid-sequence abandons it: no further CSR writes, no redirect.
- Latency: every output is registered, 1 cycle after the WB_V sample.
- Interrupt gate: an interrupt is takeable when WB_V=1 and (MSTATUS_IN[3] (MIE) or PRIVILEGE<3).
- IDLE, WB_V=1, no exception, no takeable IRQ (normal retire):
  - Opcode 0000011 (load): RF_WDATA=MEM.
  - Opcodes 0010011 / 0110011 / 0011011 / 0111011 / 0110111 / 0010111: RF_WDATA=ALU.
  - Opcodes 1101111 / 1100111 (JAL/JALR): RF_WDATA=NPC.
  - Opcode 1110011 with funct3!=0 (CSR op): RF_WDATA=CSR_RDATA, CSR_WE=1, CSR_WADDR=IR[31:20], CSR_WDATA=WB_CSR_WDATA.
  - RF_WE=1 for the above only when WB_DRID!=0.
  - PC_REDIRECT=WB_PC_MUX, REDIRECT_PC=ALU; FLUSH=WB_PC_MUX.
  - Other opcodes (store, branch, fence) produce no writes.
- Exception priority, highest first:
  - IAF(1), II(2), IAM(0), ECALL(8 if PRIVILEGE=0 else 11), SAM(6), LAM(4), SAF(7), LAF(5).
  - Any exception beats any interrupt.
  - Among interrupts, the highest IRQ index wins.
- Trap detected:
  - Instruction does not retire: no RF or CSR write.
  - Latch cause (interrupt: bit XLEN-1 set), tval (WB_TVAL for exceptions, 0 for interrupts) and epc=WB_PC.
  - Enter EPC; STALL=1 from the next cycle until return to IDLE.
- EPC: CSR_WE, address 0x341, data epc → CAUSE.
- CAUSE: CSR_WE, 0x342, cause → TVAL.
- TVAL: CSR_WE, 0x343, tval → STATUS.
- STATUS (final cycle):
  - CSR_WE, 0x300, data = MSTATUS_IN with MPIE[7]=MIE[3], MIE[3]=0, MPP[12:11]=PRIVILEGE.
  - PC_REDIRECT=1, REDIRECT_PC={MTVEC_IN[XLEN-1:2],2'b00}, FLUSH=1, TRAP_TAKEN=1.
  - Return to IDLE.
- MRET (WB_IR=0x30200073, no exception):
  - One cycle: CSR_WE, 0x300, MIE=MPIE, MPIE=1, MPP=0.
  - PC_REDIRECT=1, REDIRECT_PC=MEPC_IN, FLUSH=1.
- Sequence timing: inputs are ignored while FSM≠IDLE. Trap entry takes exactly 4 cycles of CSR writes.
- WB_V=0 in IDLE: all strobes 0.

Decomposition:
- Package wb_trap_pkg: opcode constants, CSR addresses (0x300/0x341/0x342/0x343), cause codes, IRQ_CAUSE table, FSM state enum, mstatus bit positions.
- One sub-module, trap_prio: combinational exception/interrupt priority encoder producing trap_valid, cause, is_irq.

Test Plan:
- ADDI x5 (IR=0x00A00293), ALU=10 → next cycle RF_WE=1, RF_WADDR=5, RF_WDATA=10; no CSR or redirect activity.
- Load to x0, MEM=0xDEAD → RF_WE=0.
- CSRRW x1,mscratch (IR=0x340090F3), CSR_RDATA=7, CSR_WDATA=9 → RF_WDATA=7, CSR_WE=1, CSR_WADDR=0x340, CSR_WDATA=9.
- ECALL from U, WB_PC=0x1000, MTVEC=0x8001, MSTATUS=0x8 → CSR writes on successive cycles:
  - 0x341←0x1000, 0x342←8, 0x343←0, 0x300←0x80.
  - Redirect to 0x8000 with FLUSH and TRAP_TAKEN on the 4th cycle; STALL high for 4 cycles.
- WB_EXC=0x05 (IAM+II) plus IRQ_PEND=2'b11 → cause=2.
- No exception, IRQ_PEND=2'b11, MIE=1 → cause=0x8000_0000_0000_000B.
- MIE=0, PRIVILEGE=3 → the instruction retires normally.
- MRET with MEPC_IN=0x2000 and MPIE=1 → redirect to 0x2000, mstatus MIE=1.
- RESET asserted in the CAUSE state → no 0x343 or 0x300 write, no redirect; IDLE afterwards.

Source files
------------

// File: rtl/wb_trap_pkg.sv
// rtl/wb_trap_pkg.sv - shared constants and types for the writeback/trap unit
// Contents: opcode constants, trap CSR addresses, cause codes, interrupt cause
// table, WB_EXC bit positions, mstatus bit positions, trap FSM state enum.
package wb_trap_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_REG32  = 7'b0111011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [31:0] MRET_IR = 32'h3020_0073;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    localparam int CAUSE_W = 4;

    localparam logic [CAUSE_W-1:0] CAUSE_IAM     = 4'd0;
    localparam logic [CAUSE_W-1:0] CAUSE_IAF     = 4'd1;
    localparam logic [CAUSE_W-1:0] CAUSE_II      = 4'd2;
    localparam logic [CAUSE_W-1:0] CAUSE_LAM     = 4'd4;
    localparam logic [CAUSE_W-1:0] CAUSE_LAF     = 4'd5;
    localparam logic [CAUSE_W-1:0] CAUSE_SAM     = 4'd6;
    localparam logic [CAUSE_W-1:0] CAUSE_SAF     = 4'd7;
    localparam logic [CAUSE_W-1:0] CAUSE_ECALL_U = 4'd8;
    localparam logic [CAUSE_W-1:0] CAUSE_ECALL_M = 4'd11;

    localparam int EXC_IAM   = 0;
    localparam int EXC_IAF   = 1;
    localparam int EXC_II    = 2;
    localparam int EXC_ECALL = 3;
    localparam int EXC_LAM   = 4;
    localparam int EXC_LAF   = 5;
    localparam int EXC_SAM   = 6;
    localparam int EXC_SAF   = 7;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;

    // Interrupt line index -> mcause code: line 0 timer, line 1 external.
    function automatic logic [CAUSE_W-1:0] irq_cause(input int idx);
        case (idx)
            0:       irq_cause = 4'd7;
            1:       irq_cause = 4'd11;
            default: irq_cause = 4'd0;
        endcase
    endfunction

    // The state names the CSR write currently on the output port; the
    // mstatus write is produced on the way back to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EPC,
        ST_CAUSE,
        ST_TVAL
    } trap_state_e;

endpackage

// File: rtl/trap_prio.sv
// rtl/trap_prio.sv - combinational exception/interrupt priority encoder
// Ports: exc (qualified exception vector), irq (pending lines), irq_en (global
// interrupt gate), privilege (selects the ECALL cause); trap_valid, is_irq and
// cause describe the winning trap.
module trap_prio
    import wb_trap_pkg::*;
#(
    parameter int NUM_IRQ = 2
) (
    input  logic [7:0]         exc,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               irq_en,
    input  logic [1:0]         privilege,
    output logic               trap_valid,
    output logic               is_irq,
    output logic [CAUSE_W-1:0] cause
);

    always_comb begin
        trap_valid = 1'b0;
        is_irq     = 1'b0;
        cause      = '0;
        // Ascending scan: the highest pending line is the one left standing.
        if (irq_en) begin
            for (int i = 0; i < NUM_IRQ; i++) begin
                if (irq[i]) begin
                    trap_valid = 1'b1;
                    is_irq     = 1'b1;
                    cause      = irq_cause(i);
                end
            end
        end
        // Any exception beats any interrupt; visited weakest first so each
        // stronger exception overwrites the cause.
        if (exc != 8'h00) begin
            trap_valid = 1'b1;
            is_irq     = 1'b0;
            if (exc[EXC_LAF])   cause = CAUSE_LAF;
            if (exc[EXC_SAF])   cause = CAUSE_SAF;
            if (exc[EXC_LAM])   cause = CAUSE_LAM;
            if (exc[EXC_SAM])   cause = CAUSE_SAM;
            if (exc[EXC_ECALL]) cause = (privilege == 2'd0) ? CAUSE_ECALL_U : CAUSE_ECALL_M;
            if (exc[EXC_IAM])   cause = CAUSE_IAM;
            if (exc[EXC_II])    cause = CAUSE_II;
            if (exc[EXC_IAF])   cause = CAUSE_IAF;
        end
    end

endmodule

// File: rtl/wb_trap_unit.sv
// rtl/wb_trap_unit.sv - writeback stage with machine-mode trap sequencer
// Inputs: WB_* writeback instruction bundle, IRQ_PEND, MSTATUS_IN/MTVEC_IN/
// MEPC_IN/PRIVILEGE CSR state. Outputs (all registered): RF_* register write,
// CSR_* CSR write, PC_REDIRECT/REDIRECT_PC fetch redirect, FLUSH, STALL,
// TRAP_TAKEN.
module wb_trap_unit
    import wb_trap_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int NUM_IRQ = 2
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               WB_V,
    input  logic [31:0]        WB_IR,
    input  logic [XLEN-1:0]    WB_PC,
    input  logic [XLEN-1:0]    WB_NPC,
    input  logic [XLEN-1:0]    WB_ALU_RESULT,
    input  logic [XLEN-1:0]    WB_MEM_RESULT,
    input  logic [XLEN-1:0]    WB_CSR_RDATA,
    input  logic [XLEN-1:0]    WB_CSR_WDATA,
    input  logic [4:0]         WB_DRID,
    input  logic               WB_PC_MUX,
    input  logic [7:0]         WB_EXC,
    input  logic [XLEN-1:0]    WB_TVAL,
    input  logic [NUM_IRQ-1:0] IRQ_PEND,
    input  logic [XLEN-1:0]    MSTATUS_IN,
    input  logic [XLEN-1:0]    MTVEC_IN,
    input  logic [XLEN-1:0]    MEPC_IN,
    input  logic [1:0]         PRIVILEGE,
    output logic               RF_WE,
    output logic [4:0]         RF_WADDR,
    output logic [XLEN-1:0]    RF_WDATA,
    output logic               CSR_WE,
    output logic [11:0]        CSR_WADDR,
    output logic [XLEN-1:0]    CSR_WDATA,
    output logic               PC_REDIRECT,
    output logic [XLEN-1:0]    REDIRECT_PC,
    output logic               FLUSH,
    output logic               STALL,
    output logic               TRAP_TAKEN
);

    trap_state_e state, state_n;
    logic [XLEN-1:0] cause_q, cause_n, tval_q, tval_n;

    logic               rf_we_n, csr_we_n, pc_redirect_n, flush_n, stall_n, trap_taken_n;
    logic [4:0]         rf_waddr_n;
    logic [11:0]        csr_waddr_n;
    logic [XLEN-1:0]    rf_wdata_n, csr_wdata_n, redirect_pc_n;
    logic [XLEN-1:0]    trap_status, mret_status;
    logic               rd_write;

    logic [7:0]         exc_v;
    logic               irq_en, trap_valid, is_irq;
    logic [CAUSE_W-1:0] p_cause;

    assign exc_v  = WB_V ? WB_EXC : 8'h00;
    assign irq_en = WB_V && (MSTATUS_IN[MSTATUS_MIE] || (PRIVILEGE != 2'd3));

    trap_prio #(.NUM_IRQ(NUM_IRQ)) u_prio (
        .exc        (exc_v),
        .irq        (IRQ_PEND),
        .irq_en     (irq_en),
        .privilege  (PRIVILEGE),
        .trap_valid (trap_valid),
        .is_irq     (is_irq),
        .cause      (p_cause)
    );

    always_comb begin
        trap_status = MSTATUS_IN;
        trap_status[MSTATUS_MPIE] = MSTATUS_IN[MSTATUS_MIE];
        trap_status[MSTATUS_MIE]  = 1'b0;
        trap_status[MSTATUS_MPP_LO +: 2] = PRIVILEGE;

        mret_status = MSTATUS_IN;
        mret_status[MSTATUS_MIE]  = MSTATUS_IN[MSTATUS_MPIE];
        mret_status[MSTATUS_MPIE] = 1'b1;
        mret_status[MSTATUS_MPP_LO +: 2] = 2'b00;
    end

    always_comb begin
        state_n       = state;
        cause_n       = cause_q;
        tval_n        = tval_q;
        rd_write      = 1'b0;
        rf_we_n       = 1'b0;
        rf_waddr_n    = '0;
        rf_wdata_n    = '0;
        csr_we_n      = 1'b0;
        csr_waddr_n   = '0;
        csr_wdata_n   = '0;
        pc_redirect_n = 1'b0;
        redirect_pc_n = '0;
        flush_n       = 1'b0;
        stall_n       = 1'b0;
        trap_taken_n  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (WB_V) begin
                    if (trap_valid) begin
                        // mepc is written straight from WB_PC; cause and tval
                        // are held for the following cycles.
                        state_n     = ST_EPC;
                        cause_n     = {is_irq, {(XLEN-1-CAUSE_W){1'b0}}, p_cause};
                        tval_n      = is_irq ? '0 : WB_TVAL;
                        csr_we_n    = 1'b1;
                        csr_waddr_n = CSR_MEPC;
                        csr_wdata_n = WB_PC;
                        stall_n     = 1'b1;
                    end else if (WB_IR == MRET_IR) begin
                        csr_we_n      = 1'b1;
                        csr_waddr_n   = CSR_MSTATUS;
                        csr_wdata_n   = mret_status;
                        pc_redirect_n = 1'b1;
                        redirect_pc_n = MEPC_IN;
                        flush_n       = 1'b1;
                    end else begin
                        case (WB_IR[6:0])
                            OP_LOAD: begin
                                rd_write   = 1'b1;
                                rf_wdata_n = WB_MEM_RESULT;
                            end
                            OP_IMM, OP_REG, OP_IMM32, OP_REG32, OP_LUI, OP_AUIPC: begin
                                rd_write   = 1'b1;
                                rf_wdata_n = WB_ALU_RESULT;
                            end
                            OP_JAL, OP_JALR: begin
                                rd_write   = 1'b1;
                                rf_wdata_n = WB_NPC;
                            end
                            OP_SYSTEM: begin
                                if (WB_IR[14:12] != 3'b000) begin
                                    rd_write    = 1'b1;
                                    rf_wdata_n  = WB_CSR_RDATA;
                                    csr_we_n    = 1'b1;
                                    csr_waddr_n = WB_IR[31:20];
                                    csr_wdata_n = WB_CSR_WDATA;
                                end
                            end
                            default: ;
                        endcase
                        rf_we_n       = rd_write && (WB_DRID != 5'd0);
                        rf_waddr_n    = rd_write ? WB_DRID : 5'd0;
                        pc_redirect_n = WB_PC_MUX;
                        redirect_pc_n = WB_ALU_RESULT;
                        flush_n       = WB_PC_MUX;
                    end
                end
            end
            ST_EPC: begin
                state_n     = ST_CAUSE;
                csr_we_n    = 1'b1;
                csr_waddr_n = CSR_MCAUSE;
                csr_wdata_n = cause_q;
                stall_n     = 1'b1;
            end
            ST_CAUSE: begin
                state_n     = ST_TVAL;
                csr_we_n    = 1'b1;
                csr_waddr_n = CSR_MTVAL;
                csr_wdata_n = tval_q;
                stall_n     = 1'b1;
            end
            ST_TVAL: begin
                // Final mstatus write commits the trap and redirects fetch.
                state_n       = ST_IDLE;
                csr_we_n      = 1'b1;
                csr_waddr_n   = CSR_MSTATUS;
                csr_wdata_n   = trap_status;
                pc_redirect_n = 1'b1;
                redirect_pc_n = MTVEC_IN & ~{{(XLEN-2){1'b0}}, 2'b11};
                flush_n       = 1'b1;
                stall_n       = 1'b1;
                trap_taken_n  = 1'b1;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= ST_IDLE;
            cause_q     <= '0;
            tval_q      <= '0;
            RF_WE       <= 1'b0;
            RF_WADDR    <= '0;
            RF_WDATA    <= '0;
            CSR_WE      <= 1'b0;
            CSR_WADDR   <= '0;
            CSR_WDATA   <= '0;
            PC_REDIRECT <= 1'b0;
            REDIRECT_PC <= '0;
            FLUSH       <= 1'b0;
            STALL       <= 1'b0;
            TRAP_TAKEN  <= 1'b0;
        end else begin
            state       <= state_n;
            cause_q     <= cause_n;
            tval_q      <= tval_n;
            RF_WE       <= rf_we_n;
            RF_WADDR    <= rf_waddr_n;
            RF_WDATA    <= rf_wdata_n;
            CSR_WE      <= csr_we_n;
            CSR_WADDR   <= csr_waddr_n;
            CSR_WDATA   <= csr_wdata_n;
            PC_REDIRECT <= pc_redirect_n;
            REDIRECT_PC <= redirect_pc_n;
            FLUSH       <= flush_n;
            STALL       <= stall_n;
            TRAP_TAKEN  <= trap_taken_n;
        end
    end

endmodule

// File: tb/tb_wb_trap_unit.sv
// tb/tb_wb_trap_unit.sv - self-checking bench for wb_trap_unit
module tb_wb_trap_unit;

    localparam int XLEN    = 64;
    localparam int NUM_IRQ = 2;

    logic               CLK = 1'b0;
    logic               RESET;
    logic               WB_V;
    logic [31:0]        WB_IR;
    logic [XLEN-1:0]    WB_PC, WB_NPC, WB_ALU_RESULT, WB_MEM_RESULT;
    logic [XLEN-1:0]    WB_CSR_RDATA, WB_CSR_WDATA, WB_TVAL;
    logic [4:0]         WB_DRID;
    logic               WB_PC_MUX;
    logic [7:0]         WB_EXC;
    logic [NUM_IRQ-1:0] IRQ_PEND;
    logic [XLEN-1:0]    MSTATUS_IN, MTVEC_IN, MEPC_IN;
    logic [1:0]         PRIVILEGE;
    logic               RF_WE, CSR_WE, PC_REDIRECT, FLUSH, STALL, TRAP_TAKEN;
    logic [4:0]         RF_WADDR;
    logic [11:0]        CSR_WADDR;
    logic [XLEN-1:0]    RF_WDATA, CSR_WDATA, REDIRECT_PC;

    always #5 CLK = ~CLK;

    wb_trap_unit #(.XLEN(XLEN), .NUM_IRQ(NUM_IRQ)) dut (
        .CLK(CLK), .RESET(RESET), .WB_V(WB_V), .WB_IR(WB_IR), .WB_PC(WB_PC),
        .WB_NPC(WB_NPC), .WB_ALU_RESULT(WB_ALU_RESULT), .WB_MEM_RESULT(WB_MEM_RESULT),
        .WB_CSR_RDATA(WB_CSR_RDATA), .WB_CSR_WDATA(WB_CSR_WDATA), .WB_DRID(WB_DRID),
        .WB_PC_MUX(WB_PC_MUX), .WB_EXC(WB_EXC), .WB_TVAL(WB_TVAL), .IRQ_PEND(IRQ_PEND),
        .MSTATUS_IN(MSTATUS_IN), .MTVEC_IN(MTVEC_IN), .MEPC_IN(MEPC_IN),
        .PRIVILEGE(PRIVILEGE), .RF_WE(RF_WE), .RF_WADDR(RF_WADDR), .RF_WDATA(RF_WDATA),
        .CSR_WE(CSR_WE), .CSR_WADDR(CSR_WADDR), .CSR_WDATA(CSR_WDATA),
        .PC_REDIRECT(PC_REDIRECT), .REDIRECT_PC(REDIRECT_PC), .FLUSH(FLUSH),
        .STALL(STALL), .TRAP_TAKEN(TRAP_TAKEN)
    );

    typedef struct {
        logic            rf_we;
        logic [4:0]      rf_waddr;
        logic [XLEN-1:0] rf_wdata;
        logic            csr_we;
        logic [11:0]     csr_waddr;
        logic [XLEN-1:0] csr_wdata;
        logic            pc_redirect;
        logic [XLEN-1:0] redirect_pc;
        logic            flush;
        logic            stall;
        logic            trap_taken;
    } exp_t;

    typedef struct {
        logic            v;
        logic [31:0]     ir;
        logic [XLEN-1:0] alu;
        logic [XLEN-1:0] mem;
        logic [XLEN-1:0] csr_r;
        logic [XLEN-1:0] csr_w;
        logic [4:0]      drid;
        logic            pc_mux;
        exp_t            e;
    } vec_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic exp_t none();
        exp_t e;
        e.rf_we = 1'b0; e.rf_waddr = '0; e.rf_wdata = '0;
        e.csr_we = 1'b0; e.csr_waddr = '0; e.csr_wdata = '0;
        e.pc_redirect = 1'b0; e.redirect_pc = '0;
        e.flush = 1'b0; e.stall = 1'b0; e.trap_taken = 1'b0;
        return e;
    endfunction

    function automatic exp_t e_rf(input logic [4:0] a, input logic [XLEN-1:0] d);
        exp_t e = none();
        e.rf_we = 1'b1; e.rf_waddr = a; e.rf_wdata = d;
        return e;
    endfunction

    function automatic vec_t mk(input logic v, input logic [31:0] ir, input logic [XLEN-1:0] alu,
                                input logic [XLEN-1:0] mem, input logic [XLEN-1:0] cr,
                                input logic [XLEN-1:0] cw, input logic [4:0] drid,
                                input logic pc_mux, input exp_t e);
        vec_t t;
        t.v = v; t.ir = ir; t.alu = alu; t.mem = mem; t.csr_r = cr; t.csr_w = cw;
        t.drid = drid; t.pc_mux = pc_mux; t.e = e;
        return t;
    endfunction

    task automatic check(input string tag, input exp_t e);
        bit bad = 1'b0;
        if (RF_WE !== e.rf_we) begin
            $display("FAIL %s rf_we got %0b want %0b", tag, RF_WE, e.rf_we); bad = 1'b1;
        end
        if (e.rf_we && (RF_WADDR !== e.rf_waddr || RF_WDATA !== e.rf_wdata)) begin
            $display("FAIL %s rf got x%0d=%h want x%0d=%h", tag, RF_WADDR, RF_WDATA, e.rf_waddr, e.rf_wdata);
            bad = 1'b1;
        end
        if (CSR_WE !== e.csr_we) begin
            $display("FAIL %s csr_we got %0b want %0b", tag, CSR_WE, e.csr_we); bad = 1'b1;
        end
        if (e.csr_we && (CSR_WADDR !== e.csr_waddr || CSR_WDATA !== e.csr_wdata)) begin
            $display("FAIL %s csr got %h<-%h want %h<-%h", tag, CSR_WADDR, CSR_WDATA, e.csr_waddr, e.csr_wdata);
            bad = 1'b1;
        end
        if (PC_REDIRECT !== e.pc_redirect) begin
            $display("FAIL %s pc_redirect got %0b want %0b", tag, PC_REDIRECT, e.pc_redirect); bad = 1'b1;
        end
        if (e.pc_redirect && REDIRECT_PC !== e.redirect_pc) begin
            $display("FAIL %s redirect_pc got %h want %h", tag, REDIRECT_PC, e.redirect_pc); bad = 1'b1;
        end
        if (FLUSH !== e.flush || STALL !== e.stall || TRAP_TAKEN !== e.trap_taken) begin
            $display("FAIL %s flush/stall/trap got %0b%0b%0b want %0b%0b%0b", tag,
                     FLUSH, STALL, TRAP_TAKEN, e.flush, e.stall, e.trap_taken);
            bad = 1'b1;
        end
        n_vec++;
        if (bad) n_bad++;
    endtask

    // Expectation is queued with the stimulus and retired one edge later.
    task automatic step(input string tag, input exp_t e);
        exp_t got;
        sb_q.push_back(e);
        @(posedge CLK);
        #1;
        got = sb_q.pop_front();
        check(tag, got);
    endtask

    task automatic drive_addi();
        WB_V = 1'b1; WB_IR = 32'h00A0_0293; WB_ALU_RESULT = 64'd10; WB_DRID = 5'd5;
        WB_EXC = 8'h00; IRQ_PEND = '0; WB_PC_MUX = 1'b0;
    endtask

    // Trap inputs must already be driven; later cycles carry an unrelated
    // instruction that has to be ignored while the sequence runs.
    task automatic trap_seq(input string tag, input logic [XLEN-1:0] pc, input logic [XLEN-1:0] cause,
                            input logic [XLEN-1:0] tval, input logic [XLEN-1:0] status);
        exp_t e = none();
        e.csr_we = 1'b1; e.stall = 1'b1;
        e.csr_waddr = 12'h341; e.csr_wdata = pc;
        step({tag, " mepc"}, e);
        drive_addi();
        e.csr_waddr = 12'h342; e.csr_wdata = cause;
        step({tag, " mcause"}, e);
        e.csr_waddr = 12'h343; e.csr_wdata = tval;
        step({tag, " mtval"}, e);
        e.csr_waddr = 12'h300; e.csr_wdata = status;
        e.pc_redirect = 1'b1; e.redirect_pc = 64'h8000; e.flush = 1'b1; e.trap_taken = 1'b1;
        step({tag, " mstatus"}, e);
        WB_V = 1'b0;
        step({tag, " idle"}, none());
    endtask

    vec_t vt[11];
    exp_t t;

    initial begin
        RESET = 1'b1; WB_V = 1'b0; WB_IR = '0; WB_PC = 64'h100; WB_NPC = 64'h104;
        WB_ALU_RESULT = '0; WB_MEM_RESULT = '0; WB_CSR_RDATA = '0; WB_CSR_WDATA = '0;
        WB_DRID = '0; WB_PC_MUX = 1'b0; WB_EXC = '0; WB_TVAL = '0; IRQ_PEND = '0;
        MSTATUS_IN = '0; MTVEC_IN = 64'h8001; MEPC_IN = '0; PRIVILEGE = 2'd3;

        vt[0] = mk(1, 32'h00A0_0293, 64'd10, 64'h0, 64'h0, 64'h0, 5'd5, 0, e_rf(5'd5, 64'd10));
        vt[1] = mk(1, 32'h0000_2003, 64'h0, 64'hDEAD, 64'h0, 64'h0, 5'd0, 0, none());
        vt[2] = mk(1, 32'h0000_2383, 64'h0, 64'hDEAD, 64'h0, 64'h0, 5'd7, 0, e_rf(5'd7, 64'hDEAD));
        t = e_rf(5'd1, 64'd7); t.csr_we = 1'b1; t.csr_waddr = 12'h340; t.csr_wdata = 64'd9;
        vt[3] = mk(1, 32'h3400_90F3, 64'h0, 64'h0, 64'd7, 64'd9, 5'd1, 0, t);
        t = e_rf(5'd1, 64'h104); t.pc_redirect = 1'b1; t.redirect_pc = 64'h200; t.flush = 1'b1;
        vt[4] = mk(1, 32'h0080_00EF, 64'h200, 64'h0, 64'h0, 64'h0, 5'd1, 1, t);
        t = none(); t.pc_redirect = 1'b1; t.redirect_pc = 64'h300; t.flush = 1'b1;
        vt[5] = mk(1, 32'h0000_0463, 64'h300, 64'h0, 64'h0, 64'h0, 5'd0, 1, t);
        vt[6] = mk(1, 32'h0011_2023, 64'h44, 64'h0, 64'h0, 64'h0, 5'd4, 0, none());
        vt[7] = mk(1, 32'h1234_51B7, 64'h1234_5000, 64'h0, 64'h0, 64'h0, 5'd3, 0, e_rf(5'd3, 64'h1234_5000));
        vt[8] = mk(1, 32'h0020_81BB, 64'd5, 64'h0, 64'h0, 64'h0, 5'd3, 0, e_rf(5'd3, 64'd5));
        t = none(); t.csr_we = 1'b1; t.csr_waddr = 12'h340; t.csr_wdata = 64'h55;
        vt[9] = mk(1, 32'h3400_2073, 64'h0, 64'h0, 64'h66, 64'h55, 5'd0, 0, t);
        vt[10] = mk(0, 32'h00A0_0293, 64'd10, 64'h0, 64'h0, 64'h0, 5'd5, 1, none());

        step("reset", none());
        RESET = 1'b0;

        for (int i = 0; i < 11; i++) begin
            WB_V = vt[i].v; WB_IR = vt[i].ir; WB_ALU_RESULT = vt[i].alu;
            WB_MEM_RESULT = vt[i].mem; WB_CSR_RDATA = vt[i].csr_r; WB_CSR_WDATA = vt[i].csr_w;
            WB_DRID = vt[i].drid; WB_PC_MUX = vt[i].pc_mux; WB_EXC = 8'h00; IRQ_PEND = '0;
            step($sformatf("vec%0d", i), vt[i].e);
        end

        // ECALL from U-mode
        WB_V = 1'b1; WB_IR = 32'h0000_0073; WB_PC = 64'h1000; WB_EXC = 8'h08; WB_TVAL = '0;
        WB_PC_MUX = 1'b0; MSTATUS_IN = 64'h8; PRIVILEGE = 2'd0;
        trap_seq("ecall_u", 64'h1000, 64'd8, 64'h0, 64'h80);

        // IAM + II with both interrupts pending: II wins
        WB_V = 1'b1; WB_PC = 64'h1100; WB_EXC = 8'h05; WB_TVAL = 64'hBAD; IRQ_PEND = 2'b11;
        MSTATUS_IN = 64'h8; PRIVILEGE = 2'd3;
        trap_seq("ii_prio", 64'h1100, 64'd2, 64'hBAD, 64'h1880);

        // All data-side faults at once: SAM wins
        WB_V = 1'b1; WB_PC = 64'h1200; WB_EXC = 8'hF0; WB_TVAL = 64'h44; IRQ_PEND = 2'b00;
        trap_seq("sam_prio", 64'h1200, 64'd6, 64'h44, 64'h1880);

        // Both interrupts, MIE=1 in M-mode: external wins, tval zero
        WB_V = 1'b1; WB_PC = 64'h1300; WB_EXC = 8'h00; WB_TVAL = 64'h77; IRQ_PEND = 2'b11;
        trap_seq("irq_ext", 64'h1300, 64'h8000_0000_0000_000B, 64'h0, 64'h1880);

        // Timer interrupt from U-mode with MIE=0 still taken; MPP overwritten
        WB_V = 1'b1; WB_PC = 64'h1400; IRQ_PEND = 2'b01; MSTATUS_IN = 64'h1800; PRIVILEGE = 2'd0;
        trap_seq("irq_tmr_u", 64'h1400, 64'h8000_0000_0000_0007, 64'h0, 64'h0);

        // MIE=0 in M-mode: interrupt masked, instruction retires
        drive_addi(); IRQ_PEND = 2'b11; MSTATUS_IN = 64'h0; PRIVILEGE = 2'd3;
        step("irq_masked", e_rf(5'd5, 64'd10));

        // MRET
        WB_V = 1'b1; WB_IR = 32'h3020_0073; WB_DRID = 5'd0; IRQ_PEND = 2'b00; WB_EXC = 8'h00;
        MSTATUS_IN = 64'h1880; MEPC_IN = 64'h2000;
        t = none(); t.csr_we = 1'b1; t.csr_waddr = 12'h300; t.csr_wdata = 64'h88;
        t.pc_redirect = 1'b1; t.redirect_pc = 64'h2000; t.flush = 1'b1;
        step("mret", t);

        // Reset while the mcause write is on the port abandons the trap
        WB_V = 1'b1; WB_IR = 32'h0000_0073; WB_PC = 64'h3000; WB_EXC = 8'h08;
        MSTATUS_IN = 64'h8; PRIVILEGE = 2'd0;
        t = none(); t.csr_we = 1'b1; t.stall = 1'b1; t.csr_waddr = 12'h341; t.csr_wdata = 64'h3000;
        step("rst_seq mepc", t);
        drive_addi();
        t.csr_waddr = 12'h342; t.csr_wdata = 64'd8;
        step("rst_seq mcause", t);
        RESET = 1'b1;
        step("rst_seq reset", none());
        RESET = 1'b0; WB_V = 1'b0;
        step("rst_seq quiet1", none());
        step("rst_seq quiet2", none());
        drive_addi();
        step("rst_seq idle_retire", e_rf(5'd5, 64'd10));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
